// File: rtl/matmul_seq.sv
// ---------------------------------------------------------------------------
// matmul_seq -- sequencer for the matrix-multiply datapath.
//
// Computes C = A x B for square DIM x DIM matrices of 8-bit signed elements.
// Operands come from external RAMs with one cycle of read latency. Each dot
// product is accumulated in a 16-bit saturating accumulator, and the result
// is written to an external result RAM. Addresses are row-major
// (addr = row*DIM + col).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      job start (sampled in IDLE), synchronous job cancel
//   busy, done, sat   status: not idle, one-cycle completion pulse,
//                     sticky saturation flag for the current job
//   rd_en, a_addr,    read strobe and addresses for the A and B RAMs
//   b_addr
//   a_data, b_data    signed operands, valid the cycle after rd_en
//   c_wr_en, c_addr,  result RAM write strobe, address and data
//   c_data
// ---------------------------------------------------------------------------
module matmul_seq #(
    parameter int DIM    = 4,
    parameter int ADDR_W = $clog2(DIM * DIM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     sat,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        a_addr,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic signed [7:0]        a_data,
    input  logic signed [7:0]        b_data,
    output logic                     c_wr_en,
    output logic [ADDR_W-1:0]        c_addr,
    output logic signed [15:0]       c_data
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = $clog2(DIM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          i_q, i_d;
    logic [CNT_W-1:0]          j_q, j_d;
    logic [CNT_W-1:0]          k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic                      rd_vld_q, rd_vld_d;

    logic signed [ACC_W-1:0]   a_ext, b_ext, prod;
    logic signed [ACC_W:0]     sum;

    // Sum overflowed the 16-bit range when the two top bits disagree.
    function automatic logic ovf17(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat16(input logic signed [ACC_W:0] s);
        if (!ovf17(s))
            return s[ACC_W-1:0];
        else if (s[ACC_W])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_LOAD;
            S_LOAD:  if (k_q == LAST_IDX) state_d = S_LAST;
            S_LAST:  state_d = S_WRITE;
            S_WRITE: state_d = (j_q < LAST_IDX || i_q < LAST_IDX) ? S_LOAD : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    // Counters, accumulator and saturation flag
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        sat_d = sat_q;

        a_ext = {{(ACC_W-DATA_W){a_data[DATA_W-1]}}, a_data};
        b_ext = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
        // -128 * -128 = 16384 still fits, so the 16-bit product is exact.
        prod  = a_ext * b_ext;
        sum   = {acc_q[ACC_W-1], acc_q} + {prod[ACC_W-1], prod};

        // Operand data is only looked at one cycle after a read was issued.
        if (rd_vld_q) begin
            acc_d = sat16(sum);
            if (ovf17(sum))
                sat_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                    sat_d = 1'b0;
                end
            end
            S_LOAD: begin
                k_d = (k_q == LAST_IDX) ? '0 : k_q + 1'b1;
            end
            S_WRITE: begin
                acc_d = '0;
                if (j_q < LAST_IDX) begin
                    j_d = j_q + 1'b1;
                end else if (i_q < LAST_IDX) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Abort discards the partial element; sat is kept for the host.
        if (abort && state_q != S_IDLE) begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            acc_d = '0;
        end

        rd_vld_d = (state_q == S_LOAD) && !abort;
    end

    // Outputs
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        rd_en   = (state_q == S_LOAD);
        c_wr_en = (state_q == S_WRITE);
        sat     = sat_q;
        a_addr  = addr_of(i_q, k_q);
        b_addr  = addr_of(k_q, j_q);
        c_addr  = addr_of(i_q, j_q);
        c_data  = acc_q;
    end

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;

    logic clk;
    logic rst_n;

    // DIM=2 instance
    logic              start2, abort2;
    logic              busy2, done2, sat2, rd_en2, c_wr_en2;
    logic [1:0]        a_addr2, b_addr2, c_addr2;
    logic signed [7:0] a_data2, b_data2;
    logic signed [15:0] c_data2;

    // DIM=4 instance
    logic              start4, abort4;
    logic              busy4, done4, sat4, rd_en4, c_wr_en4;
    logic [3:0]        a_addr4, b_addr4, c_addr4;
    logic signed [7:0] a_data4, b_data4;
    logic signed [15:0] c_data4;

    logic signed [7:0] mem_a2 [4];
    logic signed [7:0] mem_b2 [4];
    logic signed [7:0] mem_a4 [16];
    logic signed [7:0] mem_b4 [16];

    int vec_cnt;
    int miss_cnt;

    // Observation logs
    logic [1:0]         wr_addr2 [256];
    logic signed [15:0] wr_data2 [256];
    int                 wr_cnt2, done_cnt2, overlap_cnt2;
    logic [3:0]         wr_addr4 [64];
    logic signed [15:0] wr_data4 [64];
    logic [3:0]         rd_a4 [128];
    logic [3:0]         rd_b4 [128];
    int                 wr_cnt4, done_cnt4, rd_cnt4, overlap_cnt4;

    matmul_seq #(.DIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .sat(sat2), .rd_en(rd_en2),
        .a_addr(a_addr2), .b_addr(b_addr2), .a_data(a_data2), .b_data(b_data2),
        .c_wr_en(c_wr_en2), .c_addr(c_addr2), .c_data(c_data2)
    );

    matmul_seq #(.DIM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .sat(sat4), .rd_en(rd_en4),
        .a_addr(a_addr4), .b_addr(b_addr4), .a_data(a_data4), .b_data(b_data4),
        .c_wr_en(c_wr_en4), .c_addr(c_addr4), .c_data(c_data4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand RAMs with one cycle of read latency; X when not read.
    always @(posedge clk) begin
        if (rd_en2) begin
            a_data2 <= mem_a2[a_addr2];
            b_data2 <= mem_b2[b_addr2];
        end else begin
            a_data2 <= 'x;
            b_data2 <= 'x;
        end
        if (rd_en4) begin
            a_data4 <= mem_a4[a_addr4];
            b_data4 <= mem_b4[b_addr4];
        end else begin
            a_data4 <= 'x;
            b_data4 <= 'x;
        end
    end

    // Output monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (c_wr_en2 && wr_cnt2 < 256) begin
            wr_addr2[wr_cnt2] = c_addr2;
            wr_data2[wr_cnt2] = c_data2;
            wr_cnt2 = wr_cnt2 + 1;
        end
        if (done2) done_cnt2 = done_cnt2 + 1;
        if (rd_en2 && c_wr_en2) overlap_cnt2 = overlap_cnt2 + 1;
        if (c_wr_en4 && wr_cnt4 < 64) begin
            wr_addr4[wr_cnt4] = c_addr4;
            wr_data4[wr_cnt4] = c_data4;
            wr_cnt4 = wr_cnt4 + 1;
        end
        if (rd_en4 && rd_cnt4 < 128) begin
            rd_a4[rd_cnt4] = a_addr4;
            rd_b4[rd_cnt4] = b_addr4;
            rd_cnt4 = rd_cnt4 + 1;
        end
        if (done4) done_cnt4 = done_cnt4 + 1;
        if (rd_en4 && c_wr_en4) overlap_cnt4 = overlap_cnt4 + 1;
    end

    // Runs one DIM=2 job; reports the cycle done was seen (-1 if never) and sat in cycle 1.
    task automatic run2(output int done_cyc, output logic sat_c1);
        int n;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        sat_c1 = sat2;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        done_cyc = done2 ? n : -1;
        @(negedge clk);
        #1;
    endtask

    task automatic load2(input int a0, a1, a2, a3, b0, b1, b2, b3);
        mem_a2[0] = 8'(a0); mem_a2[1] = 8'(a1); mem_a2[2] = 8'(a2); mem_a2[3] = 8'(a3);
        mem_b2[0] = 8'(b0); mem_b2[1] = 8'(b1); mem_b2[2] = 8'(b2); mem_b2[3] = 8'(b3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({busy2, done2, sat2, rd_en2, c_wr_en2} !== 5'b0) begin
            miss_cnt++;
            $display("FAIL reset_ctrl2: got %b, want 00000", {busy2, done2, sat2, rd_en2, c_wr_en2});
        end
        vec_cnt++;
        if ({a_addr2, b_addr2, c_addr2} !== 6'b0 || c_data2 !== 16'sd0) begin
            miss_cnt++;
            $display("FAIL reset_data2: got addr %h data %0d, want 0 0", {a_addr2, b_addr2, c_addr2}, c_data2);
        end
        vec_cnt++;
        if ({busy4, done4, sat4, rd_en4, c_wr_en4} !== 5'b0 || c_data4 !== 16'sd0) begin
            miss_cnt++;
            $display("FAIL reset_dut4: got %b/%0d, want 00000/0", {busy4, done4, sat4, rd_en4, c_wr_en4}, c_data4);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int exp_d [4] = '{19, 22, 43, 50};
        int base, dbase, dc;
        logic s1;
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        base = wr_cnt2;
        dbase = done_cnt2;
        run2(dc, s1);
        vec_cnt++;
        if (dc !== 17) begin
            miss_cnt++;
            $display("FAIL basic_done_cycle: got %0d, want 17", dc);
        end
        vec_cnt++;
        if (wr_cnt2 - base !== 4) begin
            miss_cnt++;
            $display("FAIL basic_write_count: got %0d, want 4", wr_cnt2 - base);
        end
        for (int e = 0; e < 4; e++) begin
            vec_cnt++;
            if (wr_addr2[base+e] !== 2'(e) || wr_data2[base+e] !== 16'(exp_d[e])) begin
                miss_cnt++;
                $display("FAIL basic_c%0d: got addr %0d data %0d, want addr %0d data %0d",
                         e, wr_addr2[base+e], wr_data2[base+e], e, exp_d[e]);
            end
        end
        vec_cnt++;
        if (sat2 !== 1'b0 || busy2 !== 1'b0 || done_cnt2 - dbase !== 1) begin
            miss_cnt++;
            $display("FAIL basic_status: got sat %b busy %b dones %0d, want 0 0 1", sat2, busy2, done_cnt2 - dbase);
        end
    endtask

    task automatic test_saturation();
        int base, dc;
        logic s1;
        load2(-128, -128, -128, -128, -128, -128, -128, -128);
        base = wr_cnt2;
        run2(dc, s1);
        for (int e = 0; e < 4; e++) begin
            vec_cnt++;
            if (wr_data2[base+e] !== 16'sd32767) begin
                miss_cnt++;
                $display("FAIL sat_pos_c%0d: got %0d, want 32767", e, wr_data2[base+e]);
            end
        end
        vec_cnt++;
        if (sat2 !== 1'b1) begin
            miss_cnt++;
            $display("FAIL sat_pos_flag: got %b, want 1", sat2);
        end
        load2(-128, -128, -128, -128, 127, 127, 127, 127);
        base = wr_cnt2;
        run2(dc, s1);
        vec_cnt++;
        if (s1 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL sat_clear_on_start: got %b, want 0", s1);
        end
        for (int e = 0; e < 4; e++) begin
            vec_cnt++;
            if (wr_data2[base+e] !== -16'sd32512) begin
                miss_cnt++;
                $display("FAIL sat_neg_c%0d: got %0d, want -32512", e, wr_data2[base+e]);
            end
        end
        vec_cnt++;
        if (sat2 !== 1'b0 || wr_cnt2 - base !== 4) begin
            miss_cnt++;
            $display("FAIL sat_neg_flag: got sat %b writes %0d, want 0 4", sat2, wr_cnt2 - base);
        end
    endtask

    task automatic test_dim4();
        int n;
        for (int x = 0; x < 16; x++) begin
            mem_a4[x] = 8'sd127;
            mem_b4[x] = 8'sd127;
        end
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (!done4 || n !== 97) begin
            miss_cnt++;
            $display("FAIL dim4_done_cycle: got %0d (done %b), want 97", n, done4);
        end
        @(negedge clk);
        #1;
        vec_cnt++;
        if (wr_cnt4 !== 16 || sat4 !== 1'b1 || done_cnt4 !== 1) begin
            miss_cnt++;
            $display("FAIL dim4_status: got writes %0d sat %b dones %0d, want 16 1 1", wr_cnt4, sat4, done_cnt4);
        end
        for (int e = 0; e < 16; e++) begin
            vec_cnt++;
            if (wr_addr4[e] !== 4'(e) || wr_data4[e] !== 16'sd32767) begin
                miss_cnt++;
                $display("FAIL dim4_c%0d: got addr %0d data %0d, want addr %0d data 32767",
                         e, wr_addr4[e], wr_data4[e], e);
            end
        end
        for (int r = 0; r < 4; r++) begin
            vec_cnt++;
            if (rd_a4[r] !== 4'(r) || rd_b4[r] !== 4'(4 * r)) begin
                miss_cnt++;
                $display("FAIL dim4_rd%0d: got a %0d b %0d, want a %0d b %0d", r, rd_a4[r], rd_b4[r], r, 4 * r);
            end
        end
    endtask

    task automatic test_abort();
        int n, base, dbase, dc;
        logic s1;
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        base = wr_cnt2;
        dbase = done_cnt2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (n < 9) begin
            @(negedge clk);
            n++;
        end
        // cycle 9: first LOAD cycle of element 2
        vec_cnt++;
        if (rd_en2 !== 1'b1 || a_addr2 !== 2'd2) begin
            miss_cnt++;
            $display("FAIL abort_pre_state: got rd_en %b a_addr %0d, want 1 2", rd_en2, a_addr2);
        end
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        vec_cnt++;
        if (busy2 !== 1'b0 || rd_en2 !== 1'b0 || c_wr_en2 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL abort_idle: got busy %b rd_en %b wr %b, want 0 0 0", busy2, rd_en2, c_wr_en2);
        end
        repeat (20) @(negedge clk);
        #1;
        vec_cnt++;
        if (wr_cnt2 - base !== 2 || done_cnt2 !== dbase || busy2 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL abort_quiet: got writes %0d dones %0d busy %b, want 2 0 0",
                     wr_cnt2 - base, done_cnt2 - dbase, busy2);
        end
        base = wr_cnt2;
        run2(dc, s1);
        vec_cnt++;
        if (dc !== 17 || wr_cnt2 - base !== 4 || wr_data2[base] !== 16'sd19 || wr_data2[base+3] !== 16'sd50) begin
            miss_cnt++;
            $display("FAIL abort_rerun: got done %0d writes %0d c0 %0d c3 %0d, want 17 4 19 50",
                     dc, wr_cnt2 - base, wr_data2[base], wr_data2[base+3]);
        end
    endtask

    task automatic test_start_ignored();
        int n, base, dbase;
        int exp_d [4] = '{19, 22, 43, 50};
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        base = wr_cnt2;
        dbase = done_cnt2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 200) begin
            start2 = (n == 5 || n == 10);
            @(negedge clk);
            n++;
        end
        start2 = 1'b0;
        vec_cnt++;
        if (!done2 || n !== 17) begin
            miss_cnt++;
            $display("FAIL busy_start_done_cycle: got %0d, want 17", n);
        end
        @(negedge clk);
        #1;
        for (int e = 0; e < 4; e++) begin
            vec_cnt++;
            if (wr_data2[base+e] !== 16'(exp_d[e])) begin
                miss_cnt++;
                $display("FAIL busy_start_c%0d: got %0d, want %0d", e, wr_data2[base+e], exp_d[e]);
            end
        end
        vec_cnt++;
        if (done_cnt2 - dbase !== 1 || wr_cnt2 - base !== 4) begin
            miss_cnt++;
            $display("FAIL busy_start_counts: got dones %0d writes %0d, want 1 4", done_cnt2 - dbase, wr_cnt2 - base);
        end
        // start and abort together while idle
        base = wr_cnt2;
        @(negedge clk);
        start2 = 1'b1;
        abort2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        abort2 = 1'b0;
        vec_cnt++;
        if (busy2 !== 1'b0 || rd_en2 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL start_abort_idle: got busy %b rd_en %b, want 0 0", busy2, rd_en2);
        end
        repeat (8) @(negedge clk);
        #1;
        vec_cnt++;
        if (wr_cnt2 !== base || busy2 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL start_abort_quiet: got writes %0d busy %b, want 0 0", wr_cnt2 - base, busy2);
        end
    endtask

    task automatic test_reset_mid();
        int n, base, dbase;
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (n < 4) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (c_wr_en2 !== 1'b1 || c_data2 !== 16'sd19) begin
            miss_cnt++;
            $display("FAIL rstmid_pre_write: got wr %b data %0d, want 1 19", c_wr_en2, c_data2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({busy2, done2, sat2, rd_en2, c_wr_en2} !== 5'b0 || c_data2 !== 16'sd0 || c_addr2 !== 2'd0) begin
            miss_cnt++;
            $display("FAIL rstmid_async: got %b data %0d addr %0d, want 00000 0 0",
                     {busy2, done2, sat2, rd_en2, c_wr_en2}, c_data2, c_addr2);
        end
        base = wr_cnt2;
        dbase = done_cnt2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        vec_cnt++;
        if (wr_cnt2 !== base || done_cnt2 !== dbase || busy2 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rstmid_quiet: got writes %0d dones %0d busy %b, want 0 0 0",
                     wr_cnt2 - base, done_cnt2 - dbase, busy2);
        end
        vec_cnt++;
        if (overlap_cnt2 !== 0 || overlap_cnt4 !== 0) begin
            miss_cnt++;
            $display("FAIL rd_wr_overlap: got %0d/%0d cycles, want 0", overlap_cnt2, overlap_cnt4);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_cnt = 0;
        miss_cnt = 0;
        wr_cnt2 = 0; done_cnt2 = 0; overlap_cnt2 = 0;
        wr_cnt4 = 0; done_cnt4 = 0; rd_cnt4 = 0; overlap_cnt4 = 0;
        start2 = 1'b0; abort2 = 1'b0;
        start4 = 1'b0; abort4 = 1'b0;
        rst_n = 1'b0;
        load2(0, 0, 0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 16; x++) begin
            mem_a4[x] = '0;
            mem_b4[x] = '0;
        end
        test_reset();
        test_basic();
        test_saturation();
        test_dim4();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
